vec_ram_pipe: RTL and testbench

Parametrised, byte-addressed, little-endian vector RAM with single-cycle unaligned access, a valid/ready request channel and a buffered, in-order read-response channel. Next-generation replacement for the flat native vector RAM. It sits between the vector load/store unit and backing storage. Any byte address is served in one access: even/odd word banking handles reads and writes that straddle a word boundary. Backpressure is credit-based, so a stalled consumer never loses read data.

---
 rtl/vec_ram_pipe_if.sv | 28 ++
 rtl/vec_ram_pipe.sv | 170 +++++++++++++++++
 tb/tb_vec_ram_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_ram_pipe_if.sv
// Request/response bundle for vec_ram_pipe: valid/ready request channel and
// buffered read-response channel. Signal names keep the RAM's port naming.
interface vec_ram_pipe_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 24
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [BYTES-1:0]  req_strb_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;

  modport slave (
    input  req_valid_i, req_we_i, req_strb_i, req_addr_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_we_i, req_strb_i, req_addr_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/vec_ram_pipe.sv
// Byte-addressed little-endian vector RAM: even/odd word banks give single-cycle
// unaligned access; reads return in order through a credit-guarded response FIFO.
module vec_ram_pipe #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vec_ram_pipe_if.slave bus
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned WORD_W = $clog2(DEPTH);
  localparam int unsigned BIDX_W = (WORD_W > 1) ? WORD_W - 1 : 1;
  localparam int unsigned BANK_N = 2 ** BIDX_W;
  localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

  // Request decode
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic [OFF_W-1:0]  w_off;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_word_nx;
  logic [WORD_W-1:0] w_e_word;
  logic [WORD_W-1:0] w_o_word;
  logic [BIDX_W-1:0] w_e_idx;
  logic [BIDX_W-1:0] w_o_idx;

  assign w_acc     = bus.req_valid_i & bus.req_ready_o;
  assign w_wr      = w_acc & bus.req_we_i;
  assign w_rd      = w_acc & ~bus.req_we_i;
  assign w_off     = bus.req_addr_i[OFF_W-1:0];
  assign w_word    = bus.req_addr_i[OFF_W +: WORD_W];
  assign w_word_nx = w_word + WORD_W'(1);

  // Word w and w+1 always have opposite parity, so each bank sees exactly one.
  assign w_e_word = w_word[0] ? w_word_nx : w_word;
  assign w_o_word = w_word[0] ? w_word    : w_word_nx;
  assign w_e_idx  = BIDX_W'(w_e_word >> 1);
  assign w_o_idx  = BIDX_W'(w_o_word >> 1);

  generate
    if (ADDR_W > OFF_W + WORD_W) begin : g_hi_addr
      logic w_unused_hi_addr;
      assign w_unused_hi_addr = ^bus.req_addr_i[ADDR_W-1:OFF_W+WORD_W];
    end
  endgenerate

  // Write path: rotate left by off; low half lands in word w, high half in w+1
  logic [2*DATA_W-1:0] w_wdata_rot;
  logic [2*BYTES-1:0]  w_wstrb_rot;
  logic [DATA_W-1:0]   w_e_wdata;
  logic [DATA_W-1:0]   w_o_wdata;
  logic [BYTES-1:0]    w_e_strb;
  logic [BYTES-1:0]    w_o_strb;

  assign w_wdata_rot = {{DATA_W{1'b0}}, bus.req_data_i} << {w_off, 3'b000};
  assign w_wstrb_rot = {{BYTES{1'b0}}, bus.req_strb_i} << w_off;

  assign w_e_wdata = w_word[0] ? w_wdata_rot[2*DATA_W-1:DATA_W] : w_wdata_rot[DATA_W-1:0];
  assign w_o_wdata = w_word[0] ? w_wdata_rot[DATA_W-1:0]        : w_wdata_rot[2*DATA_W-1:DATA_W];
  assign w_e_strb  = w_word[0] ? w_wstrb_rot[2*BYTES-1:BYTES]   : w_wstrb_rot[BYTES-1:0];
  assign w_o_strb  = w_word[0] ? w_wstrb_rot[BYTES-1:0]         : w_wstrb_rot[2*BYTES-1:BYTES];

  // Storage banks and stage-1 read registers (contents are never reset)
  logic [DATA_W-1:0] r_bank_e [BANK_N];
  logic [DATA_W-1:0] r_bank_o [BANK_N];
  logic [DATA_W-1:0] r_s1_e;
  logic [DATA_W-1:0] r_s1_o;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (w_e_strb[k]) r_bank_e[w_e_idx][8*k +: 8] <= w_e_wdata[8*k +: 8];
        if (w_o_strb[k]) r_bank_o[w_o_idx][8*k +: 8] <= w_o_wdata[8*k +: 8];
      end
    end
    if (w_rd) begin
      r_s1_e <= r_bank_e[w_e_idx];
      r_s1_o <= r_bank_o[w_o_idx];
    end
  end

  logic             r_s1_vld;
  logic [OFF_W-1:0] r_s1_off;
  logic             r_s1_par;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld <= 1'b0;
      r_s1_off <= '0;
      r_s1_par <= 1'b0;
    end else begin
      r_s1_vld <= w_rd;
      if (w_rd) begin
        r_s1_off <= w_off;
        r_s1_par <= w_word[0];
      end
    end
  end

  // Stage 2: restore word order, rotate right by off
  logic [DATA_W-1:0] w_rd_lo;
  logic [DATA_W-1:0] w_rd_hi;
  logic [DATA_W-1:0] w_rd_data;
  logic              r_s2_vld;
  logic [DATA_W-1:0] r_s2_data;

  assign w_rd_lo   = r_s1_par ? r_s1_o : r_s1_e;
  assign w_rd_hi   = r_s1_par ? r_s1_e : r_s1_o;
  assign w_rd_data = DATA_W'({w_rd_hi, w_rd_lo} >> {r_s1_off, 3'b000});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_s2_data <= w_rd_data;
    end
  end

  // Response FIFO; head entry drives rsp_data_o directly
  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fcnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push = r_s2_vld;
  assign w_pop  = bus.rsp_valid_o & bus.rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_s2_data;
        r_wr_ptr         <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_fcnt <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Credits count reads from acceptance to pop, so the FIFO can never overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= r_cnt + CNT_W'(w_rd) - CNT_W'(w_pop);
  end

  assign bus.req_ready_o = (r_cnt < CNT_W'(RSP_DEPTH));
  assign bus.rsp_valid_o = (r_fcnt != '0);
  assign bus.rsp_data_o  = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_vec_ram_pipe.sv
// Randomised and directed bench for vec_ram_pipe against a flat byte-array model
// with an in-order expected-response queue.
module tb_vec_ram_pipe;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned RSP_DEPTH = 4;
  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned MEM_B     = DEPTH * BYTES;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vec_ram_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vec_ram_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]        mdl [MEM_B];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] rx_q  [$];
  int                rx_cyc[$];
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] hold_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mdl_rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    int unsigned base = int'(a) % MEM_B;
    for (int unsigned k = 0; k < BYTES; k++) r[8*k +: 8] = mdl[(base + k) % MEM_B];
    return r;
  endfunction

  task automatic mdl_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BYTES-1:0] s);
    int unsigned base = int'(a) % MEM_B;
    for (int unsigned k = 0; k < BYTES; k++)
      if (s[k]) mdl[(base + k) % MEM_B] = d[8*k +: 8];
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: credit rule, hold-under-backpressure, response data, model updates
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      check("credit", bus.req_ready_o, exp_q.size() < RSP_DEPTH);
      if (hold_prev) begin
        check("hold_vld", bus.rsp_valid_o, 1);
        check("hold_data", bus.rsp_data_o, hold_data);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (exp_q.size() == 0) check("spurious_rsp", 1, 0);
        else check("rdata", bus.rsp_data_o, exp_q.pop_front());
        rx_q.push_back(bus.rsp_data_o);
        rx_cyc.push_back(cyc);
      end
      hold_prev = bus.rsp_valid_o && !bus.rsp_ready_i;
      hold_data = bus.rsp_data_o;
      if (bus.req_valid_i && bus.req_ready_o) begin
        if (bus.req_we_i) mdl_wr(bus.req_addr_i, bus.req_data_i, bus.req_strb_i);
        else exp_q.push_back(mdl_rd(bus.req_addr_i));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BYTES-1:0] s);
    logic acc = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    bus.req_strb_i  = s;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready_o;
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
    if (!acc) check("req_timeout", 0, 1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 300 && rx_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
  endtask

  task automatic try_reads(input int n, output int acc);
    acc = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.req_addr_i = ADDR_W'(i * 8);
      @(negedge clk);
      if (bus.req_ready_o) acc++;
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] t;
    int acc;
    int c0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_strb_i  = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.rsp_ready_i = 1'b1;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.req_ready_o, 1);
    check("rst_valid", bus.rsp_valid_o, 0);
    check("rst_data", bus.rsp_data_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int w = 0; w < int'(DEPTH); w++)
      do_req(1'b1, ADDR_W'(w * 8), {$urandom, $urandom}, '1);

    // Aligned / partial / unaligned
    do_req(1'b1, 24'h0, 64'h1122334455667788, 8'hFF);
    do_req(1'b1, 24'h4, 64'hAABBCCDDEEFF0011, 8'h0F);
    do_req(1'b1, 24'h8, 64'h2233445566778899, 8'hFF);
    rx_q.delete();
    do_req(1'b0, 24'h0, '0, '0);
    do_req(1'b0, 24'h8, '0, '0);
    do_req(1'b0, 24'h2, '0, '0);
    wait_rx(3);
    check("dir_rd0", rx_q[0], 64'hEEFF001155667788);
    check("dir_rd8", rx_q[1], 64'h2233445566778899);
    check("dir_rd2", rx_q[2], 64'h8899EEFF00115566);

    // Straddling write
    do_req(1'b1, 24'h0D, 64'hA1A2A3A4A5A6A7A8, 8'hFF);
    rx_q.delete();
    do_req(1'b0, 24'h0D, '0, '0);
    do_req(1'b0, 24'h08, '0, '0);
    wait_rx(2);
    check("strad_rd0d", rx_q[0], 64'hA1A2A3A4A5A6A7A8);
    check("strad_rd8", rx_q[1], 64'hA6A7A85566778899);

    // Wrap from last word to word 0
    do_req(1'b1, 24'h1FFC, 64'h0102030405060708, 8'hFF);
    rx_q.delete();
    do_req(1'b0, 24'h1FFC, '0, '0);
    do_req(1'b0, 24'h0, '0, '0);
    wait_rx(2);
    check("wrap_rd", rx_q[0], 64'h0102030405060708);
    t = rx_q[1];
    check("wrap_lo", {32'h0, t[31:0]}, 64'h01020304);

    // Read latency from an empty FIFO
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 24'h8;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    check("lat_n0", bus.rsp_valid_o, 0);
    @(posedge clk);
    #1;
    check("lat_n1", bus.rsp_valid_o, 0);
    @(posedge clk);
    #1;
    check("lat_n2", bus.rsp_valid_o, 1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure
    bus.rsp_ready_i = 1'b0;
    try_reads(6, acc);
    check("bp_accepted", acc, RSP_DEPTH);
    check("bp_ready_lo", bus.req_ready_o, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_full_vld", bus.rsp_valid_o, 1);
    rx_q.delete();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_ready_at_pop", bus.req_ready_o, 0);
    @(posedge clk);
    #1;
    check("bp_ready_rise", bus.req_ready_o, 1);
    wait_rx(4);
    check("bp_rx_n", rx_q.size(), 4);

    // Streaming consecutive unaligned reads
    repeat (2) @(posedge clk);
    #1;
    rx_q.delete();
    rx_cyc.delete();
    c0 = cyc;
    for (int a = 0; a < 32; a++) do_req(1'b0, ADDR_W'(a), '0, '0);
    wait_rx(32);
    check("stream_n", rx_q.size(), 32);
    check("stream_lat", rx_cyc[0] - c0, 3);
    check("stream_gap", rx_cyc[31] - rx_cyc[0], 31);

    // Reset with reads outstanding
    repeat (2) @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b0;
    do_req(1'b0, 24'h10, '0, '0);
    do_req(1'b0, 24'h18, '0, '0);
    do_req(1'b0, 24'h20, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", bus.rsp_valid_o, 0);
    check("mrst_ready", bus.req_ready_o, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    rx_q.delete();
    do_req(1'b0, 24'h8, '0, '0);
    wait_rx(1);
    check("mrst_mem", rx_q[0], 64'hA6A7A85566778899);
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b0;
    try_reads(6, acc);
    check("mrst_credit", acc, RSP_DEPTH);
    bus.rsp_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Random mix with random backpressure and strobes
    for (int i = 0; i < 800; i++) begin
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      bus.req_valid_i = ($urandom_range(0, 2) != 0);
      bus.req_we_i    = $urandom_range(0, 1) == 1;
      bus.req_addr_i  = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 63)) : ADDR_W'($urandom);
      bus.req_data_i  = {$urandom, $urandom};
      bus.req_strb_i  = ($urandom_range(0, 7) == 0) ? '0 : BYTES'($urandom);
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
